// File: rtl/sseg_scan_decoder.sv
// Display-bus readback monitor: samples multiplexed an/sseg, decodes each scanned digit
// and publishes a 4-digit frame. Define SSEG_HEX_DECODE_EN to also accept A-F glyphs.
module sseg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err,
    output logic        scan_stalled
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [DW-1:0] TIMEOUT_MAX = DW'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] value;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] p);
        dec_t d;
        d.valid = 1'b1;
        d.blank = 1'b0;
        d.value = 4'h0;
        case (p)
            7'b1000000: d.value = 4'h0;
            7'b1111001: d.value = 4'h1;
            7'b0100100: d.value = 4'h2;
            7'b0110000: d.value = 4'h3;
            7'b0011001: d.value = 4'h4;
            7'b0010010: d.value = 4'h5;
            7'b0000010: d.value = 4'h6;
            7'b1111000: d.value = 4'h7;
            7'b0000000: d.value = 4'h8;
            7'b0010000: d.value = 4'h9;
            7'b1111111: d.blank = 1'b1;
`ifdef SSEG_HEX_DECODE_EN
            7'b0001000: d.value = 4'hA;
            7'b0000011: d.value = 4'hB;
            7'b1000110: d.value = 4'hC;
            7'b0100001: d.value = 4'hD;
            7'b0000110: d.value = 4'hE;
            7'b0001110: d.value = 4'hF;
`endif
            default:    d.valid = 1'b0;
        endcase
        return d;
    endfunction

    logic [3:0]    an_q, an_d;
    logic [6:0]    sseg_q, sseg_d;
    logic [3:0]    an_prev_q, an_prev_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    shadow_blank_q, shadow_blank_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    blank_q, blank_d;
    logic          frame_valid_q, frame_valid_d;
    logic          seg_err_q, seg_err_d;
    logic          an_err_q, an_err_d;

    logic [3:0] an_sel;
    logic       one_hot, multi_low, an_same, capture, publish;
    dec_t       dec;

    always_comb begin
        an_sel    = ~an_q;
        one_hot   = (an_sel != 4'h0) && ((an_sel & (an_sel - 4'h1)) == 4'h0);
        multi_low = (an_sel != 4'h0) && !one_hot;
        an_same   = (an_q == an_prev_q);
        dec       = decode(sseg_q);
        publish   = (mask_q == 4'hF);
    end

    always_comb begin
        an_d      = an;
        sseg_d    = sseg;
        an_prev_d = an_q;

        stab_d = '0;
        if (one_hot) begin
            if (!an_same)                stab_d = SW'(1);
            else if (stab_q != STABLE_MAX) stab_d = stab_q + SW'(1);
            else                         stab_d = stab_q;
        end
        // A saturated count on an unchanged anode means this dwell already captured.
        capture = one_hot && (stab_d == STABLE_MAX) && !(an_same && (stab_q == STABLE_MAX));

        if (!an_same)                  dwell_d = '0;
        else if (dwell_q != TIMEOUT_MAX) dwell_d = dwell_q + DW'(1);
        else                           dwell_d = dwell_q;

        an_err_d = multi_low && !an_same;

        // Publishing reads the old shadow; a same-cycle capture lands in the cleared mask.
        mask_d         = publish ? 4'h0 : mask_q;
        digits_d       = publish ? shadow_q : digits_q;
        blank_d        = publish ? shadow_blank_q : blank_q;
        frame_valid_d  = publish;
        shadow_d       = shadow_q;
        shadow_blank_d = shadow_blank_q;
        seg_err_d      = 1'b0;
        if (capture) begin
            if (dec.valid) begin
                for (int i = 0; i < 4; i++) begin
                    if (an_sel[i]) begin
                        shadow_d[i*4 +: 4] = dec.value;
                        shadow_blank_d[i]  = dec.blank;
                        mask_d[i]          = 1'b1;
                    end
                end
            end else begin
                seg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q           <= '0;
            sseg_q         <= '0;
            an_prev_q      <= '0;
            stab_q         <= '0;
            dwell_q        <= '0;
            mask_q         <= '0;
            shadow_q       <= '0;
            shadow_blank_q <= '0;
            digits_q       <= '0;
            blank_q        <= '0;
            frame_valid_q  <= 1'b0;
            seg_err_q      <= 1'b0;
            an_err_q       <= 1'b0;
        end else begin
            an_q           <= an_d;
            sseg_q         <= sseg_d;
            an_prev_q      <= an_prev_d;
            stab_q         <= stab_d;
            dwell_q        <= dwell_d;
            mask_q         <= mask_d;
            shadow_q       <= shadow_d;
            shadow_blank_q <= shadow_blank_d;
            digits_q       <= digits_d;
            blank_q        <= blank_d;
            frame_valid_q  <= frame_valid_d;
            seg_err_q      <= seg_err_d;
            an_err_q       <= an_err_d;
        end
    end

    assign digits       = digits_q;
    assign blank        = blank_q;
    assign frame_valid  = frame_valid_q;
    assign seg_err      = seg_err_q;
    assign an_err       = an_err_q;
    assign scan_stalled = (dwell_q >= TIMEOUT_MAX);

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed scans plus a randomized segment sequence
// checked against a digit-capture model driven by per-segment hold lengths.
module tb_sseg_scan_decoder;
    localparam int STABLE = 4;
    localparam int TMO    = 16;

    // 0-9, A-F, blank at index 16
    localparam logic [6:0] PAT [0:16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110,
        7'b0001110, 7'b1111111};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  sseg = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        frame_valid, seg_err, an_err, scan_stalled;

    sseg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .an(an), .sseg(sseg), .digits(digits), .blank(blank),
        .frame_valid(frame_valid), .seg_err(seg_err), .an_err(an_err),
        .scan_stalled(scan_stalled));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [19:0] fq[$];
    int          fc[$];
    int          nseg = 0;
    int          nan = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fq.push_back({blank, digits});
            fc.push_back(cyc);
        end
        if (seg_err) nseg++;
        if (an_err)  nan++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish (tests=%0d failed=%0d)", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic seg(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a;
        sseg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        fq.delete();
        fc.delete();
        nseg = 0;
        nan = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        an = 4'hF;
        sseg = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
    endtask

    task automatic scan4(input int d3, input int d2, input int d1, input int d0, input int h);
        seg(4'b1110, PAT[d0], h);
        seg(4'b1101, PAT[d1], h);
        seg(4'b1011, PAT[d2], h);
        seg(4'b0111, PAT[d3], h);
    endtask

    // Reference decode: -1 undecodable, 16 blank, else digit value
    function automatic int ref_decode(input logic [6:0] p);
        int lim;
        lim = 10;
`ifdef SSEG_HEX_DECODE_EN
        lim = 16;
`endif
        if (p == 7'h7F) return 16;
        for (int i = 0; i < lim; i++)
            if (PAT[i] == p) return i;
        return -1;
    endfunction

    initial begin
        int c0;
        logic [19:0] eq[$];
        logic [15:0] sh;
        logic [3:0]  sb, mk;
        logic [3:0]  prev, a;
        logic [6:0]  s;
        int          h, r, v, pos, exp_seg, exp_an;

        @(negedge clk);
        check("reset_outputs", {digits, blank, frame_valid, seg_err, an_err, scan_stalled}, 32'h0);

        // 1: clean scan, with exact publish latency
        do_reset();
        seg(4'b1110, PAT[4], 8);
        seg(4'b1101, PAT[3], 8);
        seg(4'b1011, PAT[2], 8);
        c0 = cyc;
        seg(4'b0111, PAT[1], 8);
        seg(4'hF, 7'h7F, 4);
        check("t1_frames", fq.size(), 1);
        if (fq.size() > 0) begin
            check("t1_digits", fq[0], {4'h0, 16'h1234});
            check("t1_latency", fc[0], c0 + 6);
        end
        check("t1_seg_err", nseg, 0);
        check("t1_an_err", nan, 0);

        // 2: one digit held too briefly, then a full scan completes the frame
        do_reset();
        seg(4'b1110, PAT[4], 8);
        seg(4'b1101, PAT[3], 3);
        seg(4'b1011, PAT[2], 8);
        seg(4'b0111, PAT[1], 8);
        seg(4'hF, 7'h7F, 4);
        check("t2_short_noframe", fq.size(), 0);
        scan4(1, 2, 3, 4, 8);
        seg(4'hF, 7'h7F, 4);
        check("t2_frames", fq.size(), 1);
        if (fq.size() > 0) check("t2_digits", fq[0], {4'h0, 16'h1234});

        // 3: two anodes low
        do_reset();
        seg(4'b1100, PAT[8], 8);
        seg(4'hF, 7'h7F, 4);
        check("t3_an_err", nan, 1);
        check("t3_seg_err", nseg, 0);
        seg(4'b1101, PAT[3], 8);
        seg(4'b1011, PAT[2], 8);
        seg(4'b0111, PAT[1], 8);
        seg(4'hF, 7'h7F, 4);
        check("t3_mask_untouched", fq.size(), 0);

        // 4: hex glyph on digit 0
        do_reset();
        seg(4'b1110, PAT[10], 8);
        seg(4'b1101, PAT[3], 8);
        seg(4'b1011, PAT[2], 8);
        seg(4'b0111, PAT[1], 8);
        seg(4'hF, 7'h7F, 4);
`ifdef SSEG_HEX_DECODE_EN
        check("t4_frames", fq.size(), 1);
        if (fq.size() > 0) check("t4_digits", fq[0], {4'h0, 16'h123A});
        check("t4_seg_err", nseg, 0);
`else
        check("t4_frames", fq.size(), 0);
        check("t4_seg_err", nseg, 1);
`endif

        // 5: stalled scan
        do_reset();
        seg(4'b1011, PAT[2], 14);
        check("t5_not_stalled", scan_stalled, 1'b0);
        seg(4'b1011, PAT[2], 6);
        check("t5_stalled", scan_stalled, 1'b1);
        seg(4'hF, 7'h7F, 2);
        check("t5_stall_clear", scan_stalled, 1'b0);

        // 6: reset mid-frame
        do_reset();
        scan4(1, 2, 3, 4, 8);
        seg(4'hF, 7'h7F, 2);
        check("t6_prev_frame", digits, 16'h1234);
        seg(4'b1110, PAT[5], 8);
        seg(4'b1101, PAT[6], 8);
        seg(4'b1011, PAT[7], 8);
        rst = 1'b0;
        #1;
        check("t6_async_reset", {digits, blank, frame_valid, seg_err, an_err, scan_stalled}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        clear_mon();
        seg(4'b0111, PAT[9], 8);
        seg(4'hF, 7'h7F, 6);
        check("t6_no_frame", fq.size(), 0);

        // Randomized segments against the capture model
        do_reset();
        sh = '0; sb = '0; mk = '0;
        exp_seg = 0; exp_an = 0;
        prev = 4'hF;
        for (int n = 0; n < 120; n++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r <= 6) begin
                    pos = $urandom_range(0, 3);
                    a = ~(4'b0001 << pos);
                end else if (r == 7) begin
                    a = 4'hF;
                end else begin
                    do a = 4'($urandom_range(0, 15)); while ($countones(~a) < 2);
                end
            end while (a == prev);
            if ($urandom_range(0, 4) == 0) s = 7'($urandom_range(0, 127));
            else s = PAT[$urandom_range(0, 16)];
            h = $urandom_range(1, 8);

            if ($countones(~a) >= 2) exp_an++;
            if ($countones(~a) == 1 && h >= STABLE) begin
                v = ref_decode(s);
                if (v < 0) begin
                    exp_seg++;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (!a[i]) begin
                            sh[i*4 +: 4] = (v == 16) ? 4'h0 : 4'(v);
                            sb[i] = (v == 16);
                            mk[i] = 1'b1;
                        end
                    end
                    if (mk == 4'hF) begin
                        eq.push_back({sb, sh});
                        mk = '0;
                    end
                end
            end
            seg(a, s, h);
            prev = a;
        end
        seg(4'hF, 7'h7F, 8);
        check("rnd_frames", fq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < fq.size(); i++)
            check($sformatf("rnd_frame%0d", i), fq[i], eq[i]);
        check("rnd_seg_err", nseg, exp_seg);
        check("rnd_an_err", nan, exp_an);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
